// File: rtl/perf_monitor_reg_pkg.sv
// Shared types, register offsets and helpers for the performance monitor register file.
package perf_monitor_reg_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [31:0] OFF_CTRL     = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS   = 32'h0000_0004;
    localparam logic [31:0] OFF_CYCLE    = 32'h0000_0008;
    localparam logic [31:0] OFF_RSVD     = 32'h0000_000C;
    localparam logic [31:0] OFF_CNT_BASE = 32'h0000_0010;
    localparam int unsigned CNT_STRIDE   = 8;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_CLR_BIT    = 1;
    localparam int unsigned CTRL_FREEZE_BIT = 2;
    localparam int unsigned CTRL_IRQ_EN_BIT = 3;

    // Field order matches the CTRL bit positions so the struct can be read out directly.
    typedef struct packed {
        logic irq_en;
        logic freeze_ovf;
        logic clr;
        logic en;
    } ctrl_reg_t;

    typedef enum logic {
        IDLE,
        RESP
    } fsm_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } perf_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } perf_reg_rsp_t;

    // Merge a write into an existing word, one byte lane per strobe bit.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_value,
                                                input logic [31:0] new_value,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = old_value;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                result[8*b +: 8] = new_value[8*b +: 8];
            end
        end
        return result;
    endfunction

    function automatic logic [31:0] evsel_offset(input int unsigned idx);
        return OFF_CNT_BASE + 32'(CNT_STRIDE * idx);
    endfunction

    function automatic logic [31:0] cnt_offset(input int unsigned idx);
        return OFF_CNT_BASE + 32'(CNT_STRIDE * idx) + 32'd4;
    endfunction

endpackage

// File: rtl/perf_monitor_counter.sv
// Single 32-bit counter with clear, byte-enabled load and increment (clear > load > inc).
module perf_monitor_counter
    import perf_monitor_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic [3:0]  load_be,
    input  logic        inc,
    output logic [31:0] value,
    output logic        ovf
);

    // A wrap only counts as an overflow when the increment actually takes effect.
    assign ovf = inc && !clear && !load && (value == 32'hFFFF_FFFF);

    // Counter state update with fixed priority between the three sources.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= apply_wstrb(value, load_value, load_be);
        end else if (inc) begin
            value <= value + 32'd1;
        end
    end

endmodule

// File: rtl/perf_monitor_regfile.sv
// Register file and event counter bank for the bus performance monitor.
module perf_monitor_regfile
    import perf_monitor_reg_pkg::*;
#(
    parameter int unsigned NUM_COUNTERS = 4,
    parameter int unsigned NUM_EVENTS   = 8,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter type         reg_req_t    = perf_monitor_reg_pkg::perf_reg_req_t,
    parameter type         reg_rsp_t    = perf_monitor_reg_pkg::perf_reg_rsp_t
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  reg_req_t              cfg_req_i,
    output reg_rsp_t              cfg_rsp_o,
    input  logic [NUM_EVENTS-1:0] ev_i,
    output logic                  irq_o
);

    fsm_state_e state_q;
    logic       ready_q;
    logic       error_q;
    logic [31:0] rdata_q;

    ctrl_reg_t  ctrl_q;
    logic [NUM_COUNTERS-1:0] status_q;
    logic [7:0] evsel_q [NUM_COUNTERS];
    logic       irq_q;

    logic [CNT_WIDTH-1:0] cnt_value [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] cnt_ovf;
    logic [NUM_COUNTERS-1:0] cnt_inc;
    logic [NUM_COUNTERS-1:0] cnt_load;
    logic [CNT_WIDTH-1:0] cycle_value;
    logic       cycle_ovf_unused;
    logic       cycle_load;

    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_write;
    logic        req_valid;

    logic        addr_ok;
    logic        sel_ctrl;
    logic        sel_status;
    logic        sel_cycle;
    logic [NUM_COUNTERS-1:0] sel_evsel;
    logic [NUM_COUNTERS-1:0] sel_cnt;
    logic [31:0] rd_value;

    logic        access;
    logic        wr_en;
    logic        ctrl_wr;
    logic        clr_pulse;
    logic [NUM_COUNTERS-1:0] status_w1c;
    logic [255:0] ev_ext;

    assign req_addr  = 32'(cfg_req_i.addr);
    assign req_wdata = 32'(cfg_req_i.wdata);
    assign req_wstrb = 4'(cfg_req_i.wstrb);
    assign req_write = cfg_req_i.write;
    assign req_valid = cfg_req_i.valid;

    assign access    = (state_q == IDLE) && req_valid;
    assign wr_en     = access && req_write && addr_ok;
    assign ctrl_wr   = wr_en && sel_ctrl && req_wstrb[0];
    assign clr_pulse = ctrl_wr && req_wdata[CTRL_CLR_BIT];
    assign status_w1c = (wr_en && sel_status && req_wstrb[0]) ? req_wdata[NUM_COUNTERS-1:0] : '0;
    assign ev_ext    = 256'(ev_i);

    // Address decode and read mux; anything unaligned, reserved or out of range is rejected.
    always_comb begin
        addr_ok    = 1'b0;
        sel_ctrl   = 1'b0;
        sel_status = 1'b0;
        sel_cycle  = 1'b0;
        sel_evsel  = '0;
        sel_cnt    = '0;
        rd_value   = '0;
        if ((req_addr[1:0] == 2'b00) && ((req_addr >> ADDR_WIDTH) == '0)) begin
            if (req_addr == OFF_CTRL) begin
                addr_ok  = 1'b1;
                sel_ctrl = 1'b1;
                rd_value = 32'(ctrl_q);
            end else if (req_addr == OFF_STATUS) begin
                addr_ok    = 1'b1;
                sel_status = 1'b1;
                rd_value   = 32'(status_q);
            end else if (req_addr == OFF_CYCLE) begin
                addr_ok   = 1'b1;
                sel_cycle = 1'b1;
                rd_value  = cycle_value;
            end
            for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
                if (req_addr == evsel_offset(i)) begin
                    addr_ok      = 1'b1;
                    sel_evsel[i] = 1'b1;
                    rd_value     = {24'd0, evsel_q[i]};
                end
                if (req_addr == cnt_offset(i)) begin
                    addr_ok    = 1'b1;
                    sel_cnt[i] = 1'b1;
                    rd_value   = cnt_value[i];
                end
            end
        end
    end

    // Per-counter increment: selected event present this cycle and the selector in range.
    always_comb begin
        cnt_inc  = '0;
        cnt_load = '0;
        for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
            cnt_inc[i]  = ctrl_q.en && (32'(evsel_q[i]) < NUM_EVENTS) && ev_ext[evsel_q[i]];
            cnt_load[i] = wr_en && sel_cnt[i] && (req_wstrb != 4'd0);
        end
    end

    assign cycle_load = wr_en && sel_cycle && (req_wstrb != 4'd0);

    genvar g;
    generate
        for (g = 0; g < NUM_COUNTERS; g++) begin : g_cnt
            perf_monitor_counter u_cnt (
                .clk        (clk_i),
                .rst_n      (rst_ni),
                .clear      (clr_pulse),
                .load       (cnt_load[g]),
                .load_value (req_wdata),
                .load_be    (req_wstrb),
                .inc        (cnt_inc[g]),
                .value      (cnt_value[g]),
                .ovf        (cnt_ovf[g])
            );
        end
    endgenerate

    perf_monitor_counter u_cycle (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .clear      (clr_pulse),
        .load       (cycle_load),
        .load_value (req_wdata),
        .load_be    (req_wstrb),
        .inc        (ctrl_q.en),
        .value      (cycle_value),
        .ovf        (cycle_ovf_unused)
    );

    // CTRL register; CLR never stores and a frozen overflow drops EN for the following cycles.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ctrl_q <= '0;
        end else begin
            if (ctrl_wr) begin
                ctrl_q.en         <= req_wdata[CTRL_EN_BIT];
                ctrl_q.freeze_ovf <= req_wdata[CTRL_FREEZE_BIT];
                ctrl_q.irq_en     <= req_wdata[CTRL_IRQ_EN_BIT];
            end
            ctrl_q.clr <= 1'b0;
            if (ctrl_q.freeze_ovf && (|cnt_ovf)) begin
                ctrl_q.en <= 1'b0;
            end
        end
    end

    // Sticky overflow flags: clear-all wins, then a fresh overflow beats a same-cycle W1C.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            status_q <= '0;
        end else if (clr_pulse) begin
            status_q <= '0;
        end else begin
            status_q <= (status_q & ~status_w1c) | cnt_ovf;
        end
    end

    // Event selectors keep the low byte of whatever software writes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
                evsel_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
                if (wr_en && sel_evsel[i] && req_wstrb[0]) begin
                    evsel_q[i] <= req_wdata[7:0];
                end
            end
        end
    end

    // Interrupt level follows the enabled status with one register stage.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= ctrl_q.irq_en && (|status_q);
        end
    end

    assign irq_o = irq_q;

    // Request/response handshake: accept in IDLE, present a one-cycle ready pulse in RESP.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (req_valid) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        error_q <= !addr_ok;
                        rdata_q <= (addr_ok && !req_write) ? rd_value : '0;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Pack the response struct from the registered handshake state.
    always_comb begin
        cfg_rsp_o       = '0;
        cfg_rsp_o.rdata = rdata_q;
        cfg_rsp_o.error = error_q;
        cfg_rsp_o.ready = ready_q;
    end

endmodule
